// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_pkg;

  // Register offsets within the 16-byte window (word aligned).
  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;
  localparam logic [3:0] UART_CTRL   = 4'hC;

  // STATUS bit positions; the FIFO count field starts at ST_COUNT.
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 4;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_OVF_CLR = 1;
  localparam int CTRL_IRQ_EN  = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-bus slice shared with the data memory: store strobe, address,
// store data, and the same-cycle read data plus window-hit flag.
interface mmio_uart_tx_if;
  logic        wen0;
  logic [31:0] addr0;
  logic [31:0] d0;
  logic [31:0] q0;
  logic        hit;

  modport master (output wen0, addr0, d0, input q0, hit);
  modport slave  (input wen0, addr0, d0, output q0, hit);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push while full is accepted only if a pop happens
// in the same cycle, which keeps back-to-back frames fed at full rate.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign rdata   = mem[rp];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the single-cycle core's data bus.
// Reads are combinational; writes land on the rising edge when wen0 & hit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h1000_0000,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           txd,
  output logic           irq
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Bus decode
  logic [3:0]  reg_off;
  logic        wr, push_req;
  logic [31:0] status_w, rdata;

  // Register file
  logic [15:0] div;
  logic        enable, irq_en, ovf, ovf_set;

  // FIFO
  logic [7:0]    fifo_q;
  logic          full, empty, pop;
  logic [CW-1:0] count;

  // Transmit engine
  tx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n, fdiv, fdiv_n, div_eff;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n;
  logic        txd_n, bit_end, busy;

  logic unused;
  assign unused = ^{bus.addr0[1:0], bus.d0[31:16]};

  assign bus.hit  = (bus.addr0[31:4] == BASE[31:4]);
  assign reg_off  = {bus.addr0[3:2], 2'b00};
  assign wr       = bus.wen0 & bus.hit;
  assign push_req = wr & (reg_off == UART_TXDATA);
  assign ovf_set  = push_req & full & ~pop;
  assign busy     = (state != IDLE);
  assign div_eff  = (div == 16'd0) ? 16'd1 : div;
  assign bit_end  = (cnt == fdiv - 16'd1);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (bus.d0[7:0]),
    .rdata (fifo_q),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // STATUS word assembly
  always_comb begin
    status_w               = '0;
    status_w[ST_EMPTY]     = empty;
    status_w[ST_FULL]      = full;
    status_w[ST_BUSY]      = busy;
    status_w[ST_OVF]       = ovf;
    status_w[ST_COUNT +: CW] = count;
  end

  // Same-cycle read mux; zero outside the window
  always_comb begin
    rdata = '0;
    case (reg_off)
      UART_STATUS: rdata = status_w;
      UART_DIV:    rdata = {16'd0, div};
      UART_CTRL:   rdata = {29'd0, irq_en, 1'b0, enable};
      default:     rdata = '0;
    endcase
    bus.q0 = bus.hit ? rdata : 32'd0;
  end

  // Configuration registers and sticky overflow (a new drop beats a clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= DIV_RESET;
      enable <= 1'b1;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr && reg_off == UART_DIV) div <= bus.d0[15:0];
      if (wr && reg_off == UART_CTRL) begin
        enable <= bus.d0[CTRL_EN];
        irq_en <= bus.d0[CTRL_IRQ_EN];
      end
      if (ovf_set)
        ovf <= 1'b1;
      else if (wr && reg_off == UART_CTRL && bus.d0[CTRL_OVF_CLR])
        ovf <= 1'b0;
    end
  end

  // Frame sequencing: next state, bit timing, pops, and the next txd level
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    idx_n   = idx;
    sh_n    = sh;
    fdiv_n  = fdiv;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable && !empty) begin
          pop     = 1'b1;
          state_n = START;
          sh_n    = fifo_q;
          fdiv_n  = div_eff;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (enable && !empty) begin
            pop     = 1'b1;
            state_n = START;
            sh_n    = fifo_q;
            fdiv_n  = div_eff;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // txd is registered from the next state so the line moves with the FSM
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = sh_n[idx_n];
      default: txd_n = 1'b1;
    endcase
  end

  // Transmit engine registers; reset abandons any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      fdiv  <= 16'd1;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      fdiv  <= fdiv_n;
      txd   <= txd_n;
    end
  end

  // Completion interrupt, one edge behind its inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= irq_en & empty & ~busy;
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with hand-computed expectations.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk, rst, txd, irq;
  int   vectors, miscompares;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.BASE(BASE), .DEPTH(4), .DIV_RESET(16'd868)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd),
    .irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr0 = a;
    bus.d0    = d;
    bus.wen0  = 1'b1;
    @(posedge clk);
    #1;
    bus.wen0  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr0 = a;
    #1;
    d = bus.q0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j, input int div);
    int p;
    p = j / div;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b want 1", txd); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    rd(BASE + 32'h4, v);
    vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL reset_status: got %h want 00000001", v); end
    rd(BASE + 32'hC, v);
    vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL reset_ctrl: got %h want 00000001", v); end
    rd(BASE + 32'h8, v);
    vectors++; if (v !== 32'd868) begin miscompares++; $display("FAIL reset_div: got %0d want 868", v); end
    rd(32'h0000_0004, v);
    vectors++; if (v !== 32'h0 || bus.hit !== 1'b0) begin miscompares++; $display("FAIL miss_read: got q0=%h hit=%b want 0/0", v, bus.hit); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    logic       e;
    b = 8'h55;
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, {24'd0, b});           // edge N
    bus.addr0 = BASE + 32'h4;
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk); #1;
      e = frame_bit(b, k - 1, 4);
      vectors++; if (txd !== e) begin miscompares++; $display("FAIL frame55_txd k=%0d: got %b want %b", k, txd, e); end
      if (k == 40) begin
        vectors++; if (bus.q0[2] !== 1'b1) begin miscompares++; $display("FAIL frame55_busy_hi: got %b want 1", bus.q0[2]); end
      end
      if (k == 41) begin
        vectors++; if (bus.q0[2] !== 1'b0) begin miscompares++; $display("FAIL frame55_busy_lo: got %b want 0", bus.q0[2]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bs [2];
    logic       e;
    bs[0] = 8'hA0; bs[1] = 8'h0F;
    wr(BASE + 32'h8, 32'd2);
    wr(BASE + 32'hC, 32'h5);
    bus.addr0 = BASE; bus.d0 = 32'hA0; bus.wen0 = 1'b1;
    @(posedge clk); #1;             // edge N
    bus.d0 = 32'h0F;
    @(posedge clk); #1;             // edge N+1
    bus.wen0 = 1'b0;
    bus.addr0 = BASE + 32'h4;
    for (int k = 1; k <= 42; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k <= 40) begin
        e = frame_bit(bs[(k-1)/20], (k-1) % 20, 2);
        vectors++; if (txd !== e) begin miscompares++; $display("FAIL b2b_txd k=%0d: got %b want %b", k, txd, e); end
      end
      if (k == 1 || k == 21 || k == 41) begin
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL b2b_irq_lo k=%0d: got %b want 0", k, irq); end
      end
      if (k == 41) begin
        vectors++; if (bus.q0 !== 32'h1) begin miscompares++; $display("FAIL b2b_status_end: got %h want 00000001", bus.q0); end
      end
      if (k == 42) begin
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL b2b_irq_hi: got %b want 1", irq); end
      end
    end
    wr(BASE + 32'hC, 32'h1);
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0]  bs [4];
    logic        e, ok;
    bs[0] = 8'h11; bs[1] = 8'h22; bs[2] = 8'h33; bs[3] = 8'h44;
    wr(BASE + 32'hC, 32'h0);
    for (int i = 0; i < 4; i++) wr(BASE, {24'd0, bs[i]});
    wr(BASE, 32'h55);
    rd(BASE + 32'h4, v);
    vectors++; if (v !== 32'h4A) begin miscompares++; $display("FAIL ovf_status: got %h want 0000004a", v); end
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL ovf_txd_idle: got %b want 1", txd); end
    bus.addr0 = BASE + 32'hC; bus.d0 = 32'h3; bus.wen0 = 1'b1;
    #1;
    vectors++; if (bus.q0 !== 32'h0) begin miscompares++; $display("FAIL ctrl_pre_edge: got %h want 00000000", bus.q0); end
    @(posedge clk); #1;             // edge M
    bus.wen0 = 1'b0;
    bus.addr0 = BASE + 32'h4;
    #1;
    vectors++; if (bus.q0 !== 32'h42) begin miscompares++; $display("FAIL ovf_cleared: got %h want 00000042", bus.q0); end
    for (int k = 1; k <= 81; k++) begin
      @(posedge clk); #1;
      if (k <= 80) begin
        e = frame_bit(bs[(k-1)/20], (k-1) % 20, 2);
        vectors++; if (txd !== e) begin miscompares++; $display("FAIL ovf_txd k=%0d: got %b want %b", k, txd, e); end
      end
      if (k == 1) begin
        vectors++; if (bus.q0 !== 32'h34) begin miscompares++; $display("FAIL ovf_first_pop: got %h want 00000034", bus.q0); end
      end
      if (k == 81) begin
        vectors++; if (bus.q0 !== 32'h1) begin miscompares++; $display("FAIL ovf_drained: got %h want 00000001", bus.q0); end
      end
    end
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; if (txd !== 1'b1) ok = 1'b0; end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ovf_dropped_byte_sent: got %b want 1", ok); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    logic        ok;
    wr(BASE, 32'h00);               // edge N
    wr(BASE, 32'h00);               // edge N+1
    repeat (5) @(posedge clk);
    #1;                             // after edge N+6: DATA bit 1
    vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL mid_data_txd: got %b want 0", txd); end
    rst = 1'b1;
    #1;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL rst_txd_async: got %b want 1", txd); end
    rd(BASE + 32'h4, v);
    vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL rst_status: got %h want 00000001", v); end
    @(posedge clk); #1;
    rst = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 30; k++) begin @(posedge clk); #1; if (txd !== 1'b1) ok = 1'b0; end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rst_no_frames: got %b want 1", ok); end
    rd(BASE + 32'h8, v);
    vectors++; if (v !== 32'd868) begin miscompares++; $display("FAIL rst_div: got %0d want 868", v); end
  endtask

  task automatic test_out_of_window();
    logic [31:0] v;
    logic        ok;
    @(posedge clk); #1;
    wr(BASE + 32'h20, 32'h77);
    vectors++; if (bus.hit !== 1'b0 || bus.q0 !== 32'h0) begin miscompares++; $display("FAIL oow_hi: got hit=%b q0=%h want 0/0", bus.hit, bus.q0); end
    wr(BASE - 32'h4, 32'h3);
    vectors++; if (bus.hit !== 1'b0 || bus.q0 !== 32'h0) begin miscompares++; $display("FAIL oow_lo: got hit=%b q0=%h want 0/0", bus.hit, bus.q0); end
    wr(BASE + 32'h28, 32'h5);
    rd(BASE + 32'h4, v);
    vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL oow_status: got %h want 00000001", v); end
    rd(BASE + 32'h8, v);
    vectors++; if (v !== 32'd868) begin miscompares++; $display("FAIL oow_div: got %0d want 868", v); end
    rd(BASE + 32'hC, v);
    vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL oow_ctrl: got %h want 00000001", v); end
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; if (txd !== 1'b1) ok = 1'b0; end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL oow_txd: got %b want 1", ok); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.wen0 = 1'b0;
    bus.addr0 = '0;
    bus.d0 = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_out_of_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that answers the single-cycle RISC-V core's data-bus accesses, the same bus the data memory serves. It sits beside the data memory, decodes its own 16-byte address window, and accepts byte writes into a small FIFO. It serialises the bytes as 8N1 frames on `txd`. Reads return status and configuration in the same cycle, as the single-cycle core requires, and the top-level mux selects it when `hit` is high.

## Interface
- `BASE`, default 32'h1000_0000: window base, 16-byte aligned.
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `DIV_RESET`, default 16'd868: reset baud divisor (clk cycles per bit).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wen0`  in  1  CPU store strobe (MemWrite).
- `addr0`  in  32  byte address (ALUResult).
- `d0`  in  32  store data; only [7:0] is used for TXDATA.
- `q0`  out  32  combinational read data; 0 when `hit`=0.
- `hit`  out  1  combinational: `addr0[31:4]==BASE[31:4]`.
- `txd`  out  1  serial output, registered, idle high.
- `irq`  out  1  registered: `irq_en & fifo_empty & ~busy`.

## Operation
- Register offsets (`addr0[3:0]`, word-aligned; `addr0[1:0]` ignored):
  - 0x0 TXDATA: a write pushes d0[7:0]; reads return 0.
  - 0x4 STATUS (read-only): [0] empty, [1] full, [2] busy, [3] overflow (sticky), [4+:N] count, N=$clog2(DEPTH)+1.
  - 0x8 DIV: [15:0] R/W, reset DIV_RESET. A value of 0 is treated as 1.
  - 0xC CTRL: [0] enable (reset 1), [2] irq_en (reset 0). Writing [1]=1 clears overflow; [1] reads 0.
- A write occurs on the rising edge when `wen0 & hit`. Writes with `hit`=0 have no effect.
- Push is accepted when count<DEPTH, or when a pop happens in the same cycle. Otherwise the byte is dropped and overflow is set.
- When overflow is set and cleared in the same cycle, set wins.
- FSM states IDLE, START, DATA, STOP:
  - IDLE→START when enable & ~empty. This pops the FIFO, latches the byte, and latches DIV as the frame divisor.
  - START drives 0 for one bit period, then goes to DATA.
  - DATA sends 8 bits LSB-first, one bit period each, using a 3-bit index, then goes to STOP.
  - STOP drives 1 for one bit period. If enable & ~empty it goes straight to START with a pop and relatch; otherwise it goes to IDLE.
- busy = state≠IDLE.
- Clearing enable mid-frame lets the current frame finish and starts no new frame. FIFO contents are retained.
- A DIV write mid-frame takes effect from the next frame.
- Bit counter: counts 0..div-1 and wraps at the bit boundary, where the FSM advances.
- Reset at any point: FSM goes to IDLE, FIFO is emptied, overflow=0, DIV=DIV_RESET, CTRL=0x1, `txd`=1, `irq`=0. An in-flight frame is abandoned.

## Timing
- Reset values: `txd`=1, `irq`=0. `q0`/`hit` are combinational from address and state.
- TXDATA write at edge N, with the block idle, enabled and the FIFO empty:
  - FSM is in START from edge N+1, and `txd`=0 from N+1.
  - Each bit lasts exactly div cycles. The frame occupies 10·div cycles.
  - `busy` reads 1 from N+1. It returns to 0 at edge N+1+10·div if no further data is queued.
- Back-to-back frames have no idle cycle between stop and start.
- STATUS read in the same cycle as a write returns pre-edge values.
- `irq` updates one edge after its inputs change.

## Structure
- Package `uart_pkg` holds:
  - offset constants `UART_TXDATA`/`UART_STATUS`/`UART_DIV`/`UART_CTRL`;
  - STATUS/CTRL bit-index constants;
  - `typedef enum logic [1:0] {IDLE,START,DATA,STOP} tx_state_t`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): push/pop/full/empty/count, with simultaneous push+pop legal when full.
- Shifter, FSM and register file stay in `mmio_uart_tx`.

## Test plan
- Reset, then read STATUS → 0x1 (empty). Reads of CTRL → 0x1 and DIV → 868. `txd`=1, `irq`=0. Reads with `hit`=0 return 0.
- DIV=4, write 0x55 at edge N → `txd`=0 during N+1..N+4, then bits 1,0,1,0,1,0,1,0 of 4 cycles each, then stop high. `busy` falls at N+41.
- DIV=2, write 0xA0 then 0x0F on consecutive cycles → two contiguous 20-cycle frames with no idle gap. `irq` (irq_en=1) asserts one edge after the second stop bit.
- CTRL=0 (disabled), write 5 bytes → STATUS count=4, full=1, overflow=1, and the fifth byte is dropped. Writing CTRL=0x3 re-enables, clears overflow, and transmits 4 frames.
- Assert `rst` mid-DATA of a frame → `txd`=1 immediately. STATUS reads 0x1 and no further frames are sent.
- Write to BASE+0x20 and to BASE−4 → no state change, `hit`=0, `q0`=0.
